// File: rtl/fib_request_ctrl.sv
// Request/response controller around an iterative Fibonacci datapath (F0=F1=1).
// Accepts an index, runs one addition per cycle, then returns F_n with a carry-out flag.
module fib_request_ctrl #(
   parameter int DATA_WIDTH = 4,
   parameter int IDX_WIDTH  = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [IDX_WIDTH-1:0]  in_idx,
   input  logic                  abort,
   output logic                  busy,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_ovf
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] a_q, a_d;
   logic [DATA_WIDTH-1:0] b_q, b_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [IDX_WIDTH-1:0]  cnt_q, cnt_d;
   logic                  ovf_q, ovf_d;
   logic                  outOvf_q, outOvf_d;
   logic [DATA_WIDTH:0]   sum;

   // The extra top bit of the sum is the carry out of the value path.
   assign sum = {1'b0, a_q} + {1'b0, b_q};

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      cnt_d    = cnt_q;
      ovf_d    = ovf_q;
      data_d   = data_q;
      outOvf_d = outOvf_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d   = DATA_WIDTH'(1);
               b_d   = DATA_WIDTH'(1);
               cnt_d = in_idx;
               ovf_d = 1'b0;
               // F0 and F1 need no additions, so they skip RUN entirely.
               if (in_idx <= IDX_WIDTH'(1)) begin
                  state_d  = DONE;
                  data_d   = DATA_WIDTH'(1);
                  outOvf_d = 1'b0;
               end else begin
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            if (abort) begin
               state_d = IDLE;
            end else begin
               a_d   = b_q;
               b_d   = sum[DATA_WIDTH-1:0];
               cnt_d = cnt_q - IDX_WIDTH'(1);
               ovf_d = ovf_q | sum[DATA_WIDTH];
               // Leaving at cnt==2 means the counter can never wrap below zero.
               if (cnt_q == IDX_WIDTH'(2)) begin
                  state_d  = DONE;
                  data_d   = sum[DATA_WIDTH-1:0];
                  outOvf_d = ovf_q | sum[DATA_WIDTH];
               end
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         a_q      <= DATA_WIDTH'(1);
         b_q      <= DATA_WIDTH'(1);
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
         data_q   <= '0;
         outOvf_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         cnt_q    <= cnt_d;
         ovf_q    <= ovf_d;
         data_q   <= data_d;
         outOvf_q <= outOvf_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign out_valid = (state_q == DONE);
   assign out_data  = data_q;
   assign out_ovf   = outOvf_q;

endmodule

// File: tb/tb_fib_request_ctrl.sv
// Directed bench for fib_request_ctrl with DATA_WIDTH=4, IDX_WIDTH=4.
// Expected Fibonacci values and latencies are hand-computed constants.
module tb_fib_request_ctrl;

   logic       clk;
   logic       reset;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_idx;
   logic       abort;
   logic       busy;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_data;
   logic       out_ovf;

   int total = 0;
   int bad   = 0;
   int lat;
   int seenValid;

   fib_request_ctrl #(.DATA_WIDTH(4), .IDX_WIDTH(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_idx    (in_idx),
      .abort     (abort),
      .busy      (busy),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ovf   (out_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Waits (bounded) for out_valid; lat counts rising edges since the acceptance edge.
   task automatic waitResult();
      lat = 1;
      @(negedge clk);
      checkOutput("inReadyLowAfterAccept", 32'(in_ready), 32'd0);
      while (!out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic applyStimulus(input logic [3:0] idx, input logic holdAbort);
      @(negedge clk);
      checkOutput("inReadyBeforeReq", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_idx   = idx;
      abort    = holdAbort;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      abort    = 1'b0;
   endtask

   task automatic runReq(input string tag, input logic [3:0] idx, input logic holdAbort,
                         input int expLat, input logic [3:0] expData, input logic expOvf);
      applyStimulus(idx, holdAbort);
      waitResult();
      checkOutput({tag, "_latency"}, 32'(lat), 32'(expLat));
      checkOutput({tag, "_data"}, 32'(out_data), 32'(expData));
      checkOutput({tag, "_ovf"}, 32'(out_ovf), 32'(expOvf));
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      checkOutput({tag, "_backToIdle"}, 32'(in_ready), 32'd1);
      checkOutput({tag, "_validDropped"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_idx    = '0;
      abort     = 1'b0;
      out_ready = 1'b0;
      #12;
      checkOutput("rstOutValid", 32'(out_valid), 32'd0);
      checkOutput("rstBusy", 32'(busy), 32'd0);
      checkOutput("rstInReady", 32'(in_ready), 32'd1);
      checkOutput("rstOutData", 32'(out_data), 32'd0);
      checkOutput("rstOutOvf", 32'(out_ovf), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // Trivial indices, normal runs and wrap-around cases.
      runReq("idx0", 4'd0, 1'b0, 1, 4'd1, 1'b0);
      runReq("idx1", 4'd1, 1'b0, 1, 4'd1, 1'b0);
      runReq("idx5", 4'd5, 1'b0, 5, 4'd8, 1'b0);
      runReq("idx6", 4'd6, 1'b0, 6, 4'd13, 1'b0);
      runReq("idx7", 4'd7, 1'b0, 7, 4'd5, 1'b1);
      runReq("idx2AbortInIdle", 4'd2, 1'b1, 2, 4'd2, 1'b0);
      runReq("idx15", 4'd15, 1'b0, 15, 4'd11, 1'b1);

      // Consumer stalls: result must hold until out_ready.
      applyStimulus(4'd4, 1'b0);
      waitResult();
      checkOutput("hold_latency", 32'(lat), 32'd4);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("hold_valid", 32'(out_valid), 32'd1);
         checkOutput("hold_data", 32'(out_data), 32'd5);
         checkOutput("hold_inReady", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      checkOutput("hold_idleAfterReady", 32'(in_ready), 32'd1);
      checkOutput("hold_validDropped", 32'(out_valid), 32'd0);

      // Abort on the second RUN edge.
      applyStimulus(4'd10, 1'b0);
      @(posedge clk);
      @(negedge clk);
      checkOutput("abort_busyInRun", 32'(busy), 32'd1);
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      checkOutput("abort_idle", 32'(in_ready), 32'd1);
      checkOutput("abort_notBusy", 32'(busy), 32'd0);
      seenValid = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (out_valid) seenValid++;
      end
      checkOutput("abort_noResult", 32'(seenValid), 32'd0);
      runReq("idx3AfterAbort", 4'd3, 1'b0, 3, 4'd3, 1'b0);

      // Asynchronous reset in the middle of a run.
      applyStimulus(4'd12, 1'b0);
      repeat (3) @(posedge clk);
      #2;
      checkOutput("midRun_busyBefore", 32'(busy), 32'd1);
      reset = 1'b1;
      #1;
      checkOutput("midRun_outValid", 32'(out_valid), 32'd0);
      checkOutput("midRun_busy", 32'(busy), 32'd0);
      checkOutput("midRun_inReady", 32'(in_ready), 32'd1);
      @(negedge clk);
      reset = 1'b0;
      runReq("idx5AfterReset", 4'd5, 1'b0, 5, 4'd8, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
